// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM states, memory-port owner and default widths.
package run_ctrl_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DONE,
    TMO
  } state_e;

  typedef enum logic {
    OWN_HOST,
    OWN_CORE
  } owner_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over increment) that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer and data-memory arbiter between host and single-cycle core.
// Define RUN_CTRL_WDOG_EN to enable the MAX_CYCLES watchdog and the TMO state.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned RST_CYC    = 2,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  input  logic          core_done,
  output logic          core_reset,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam int unsigned    PW         = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [PW-1:0]  PRIME_LAST = PW'(RST_CYC - 1);
  localparam logic [CW-1:0]  WDOG_LAST  = CW'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] prime_q, prime_d;
  owner_e        owner;
  logic          host_phase;
  logic          run_start;
  logic          wdog_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
    end
  end

  assign host_phase = (state_q == IDLE) || (state_q == DONE) || (state_q == TMO);
  assign run_start  = host_phase && start;

`ifdef RUN_CTRL_WDOG_EN
  assign wdog_hit = (cycle_count == WDOG_LAST);
  assign timeout  = (state_q == TMO);
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LAST;
  assign wdog_hit    = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    unique case (state_q)
      IDLE, DONE, TMO: if (start) state_d = PRIME;
      PRIME: begin
        if (prime_q == PRIME_LAST) begin
          state_d = RUN;
          prime_d = '0;
        end else begin
          prime_d = prime_q + 1'b1;
        end
      end
      // A halt seen on the watchdog's last cycle still ends the run cleanly.
      RUN: begin
        if (core_done)     state_d = DONE;
        else if (wdog_hit) state_d = TMO;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner = (state_q == RUN) ? OWN_CORE : OWN_HOST;

  always_comb begin
    mem_we    = host_gnt && host_we;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (owner == OWN_CORE) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  // Host requests outside its window are simply dropped, never queued.
  assign host_gnt   = host_phase && host_req;
  assign host_rdata = mem_rdata;
  assign core_rdata = mem_rdata;
  assign core_reset = (owner == OWN_HOST);
  assign busy       = (state_q == PRIME) || (state_q == RUN);
  assign done       = (state_q == DONE);

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (run_start),
    .inc_i   (state_q == RUN),
    .count_o (cycle_count)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed-plus-random bench for run_ctrl with a behavioural memory and run-schedule model.
module tb_run_ctrl;

  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int CW         = 5;
  localparam int RST_CYC    = 2;
  localparam int MAX_CYCLES = 16;
`ifdef RUN_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
  localparam int NMAX = MAX_CYCLES;
`else
  localparam bit WDOG = 1'b0;
  localparam int NMAX = 40;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst, start;
  logic          host_req, host_we, host_gnt;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          core_we, core_done, core_reset;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, timeout;
  logic [CW-1:0] cycle_count;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] mem_ref [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  run_ctrl #(
    .AW(AW), .DW(DW), .CW(CW), .RST_CYC(RST_CYC), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .reset(rst), .start(start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_done(core_done), .core_reset(core_reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic quiet();
    start = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    core_we = 0; core_addr = '0; core_wdata = '0; core_done = 0;
  endtask

  // One host cycle in a host-owned state; reads are checked against the model.
  task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    #1;
    check("host_gnt", host_gnt, 1);
    check("host_mem_we", mem_we, we);
    if (!we) check("host_rdata", host_rdata, mem_ref[a]);
    else mem_ref[a] = d;
    @(negedge clk);
    quiet();
  endtask

  // Start (with a same-cycle preload), RST_CYC prime cycles, then n run cycles.
  task automatic do_run(input int n, input bit finish, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
    bit exp_tmo;
    bit exp_host;
    start = 1; host_req = 1; host_we = 1; host_addr = pa; host_wdata = pd;
    #1;
    check("start_gnt", host_gnt, 1);
    mem_ref[pa] = pd;
    @(negedge clk);
    quiet();
    for (int p = 0; p < RST_CYC; p++) begin
      start = 1; host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = DW'($urandom);
      #1;
      check("prime_busy", busy, 1);
      check("prime_core_reset", core_reset, 1);
      check("prime_gnt", host_gnt, 0);
      check("prime_mem_we", mem_we, 0);
      check("prime_done", done, 0);
      check("prime_timeout", timeout, 0);
      check("prime_count", cycle_count, 0);
      @(negedge clk);
      quiet();
    end
    for (int i = 1; i <= n; i++) begin
      host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = DW'($urandom);
      core_we = 1'($urandom_range(0, 1));
      core_addr = AW'($urandom_range(32, 127));
      core_wdata = DW'($urandom);
      if (i == 1) begin core_we = 0; core_addr = pa; end
      if (i == 3) begin core_we = 1; core_addr = 8'h20; core_wdata = 8'h33; end
      start = (i == 2);
      core_done = finish && (i == n);
      #1;
      check("run_core_reset", core_reset, 0);
      check("run_busy", busy, 1);
      check("run_gnt", host_gnt, 0);
      check("run_mem_addr", mem_addr, core_addr);
      check("run_mem_we", mem_we, core_we);
      check("run_mem_wdata", mem_wdata, core_wdata);
      check("run_core_rdata", core_rdata, mem_ref[core_addr]);
      check("run_count", cycle_count, sat(i - 1));
      if (core_we) mem_ref[core_addr] = core_wdata;
      @(negedge clk);
      quiet();
    end
    exp_tmo  = WDOG && !finish && (n >= MAX_CYCLES);
    exp_host = finish || exp_tmo;
    #1;
    check("end_done", done, finish);
    check("end_timeout", timeout, exp_tmo);
    check("end_busy", busy, !exp_host);
    check("end_core_reset", core_reset, exp_host);
    check("end_count", cycle_count, sat(n));
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      mem[k] = '0;
      mem_ref[k] = '0;
    end
    quiet();
    rst = 1;
    #1;
    check("rst_core_reset", core_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_count", cycle_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    host_access(1, 8'h10, 8'h5A);
    host_access(0, 8'h10, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(128, 255));
      host_access(1, a, DW'($urandom));
      host_access(0, a, 8'h00);
    end

    core_done = 1;
    @(negedge clk);
    #1;
    check("idle_ignores_core_done", busy, 0);
    check("idle_no_done", done, 0);
    @(negedge clk);
    quiet();

    do_run(7, 1, 8'h00, 8'h03);
    core_done = 1;
    host_access(0, 8'h10, 8'h00);
    #1;
    check("done_holds", done, 1);
    check("done_count_frozen", cycle_count, 7);
    host_access(0, 8'h20, 8'h00);
    host_access(0, 8'h00, 8'h00);

    for (int r = 0; r < 3; r++) begin
      do_run($urandom_range(1, NMAX), 1, AW'($urandom_range(128, 255)), DW'($urandom));
      host_access(0, 8'h20, 8'h00);
    end
    do_run(NMAX, 1, 8'h81, 8'hC3);

    do_run(3, 0, 8'h01, 8'h77);
    rst = 1;
    #1;
    check("midrun_rst_core_reset", core_reset, 1);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_count", cycle_count, 0);
    check("midrun_rst_done", done, 0);
    @(negedge clk);
    rst = 0;
    host_access(0, 8'h01, 8'h00);
    host_access(0, 8'h20, 8'h00);

    do_run(MAX_CYCLES, 0, 8'h90, 8'h11);
`ifdef RUN_CTRL_WDOG_EN
    host_access(0, 8'h10, 8'h00);
    do_run(4, 1, 8'h02, 8'h44);
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;
    host_access(0, 8'h10, 8'h00);
    host_access(0, 8'h90, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Sequences one program run of the single-cycle core and arbitrates the data-memory port between the host (bench/loader) and the core.
- Host preloads operands, pulses start, waits for done, then reads results.
- The core is held in reset whenever it is not running.
- Sits between top_level's core datapath and dat_mem.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data width
- CW, 16, cycle-counter width
- RST_CYC, 2, core-reset hold cycles in PRIME (>=1)
- MAX_CYCLES, 4096, watchdog limit (used only with RUN_CTRL_WDOG_EN)

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  single-cycle run request
- host_req  in  1  host memory access request
- host_we  in  1  host write enable (qualified by host_req)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access granted this cycle
- host_rdata  out  DW  read data to host
- core_we  in  1  core MemWrite
- core_addr  in  AW  core address
- core_wdata  in  DW  core store data
- core_rdata  out  DW  read data to core
- core_done  in  1  core halt indication (all-ones instruction)
- core_reset  out  1  reset to PC/reg_file/Branch
- mem_we  out  1  to dat_mem wr_en
- mem_addr  out  AW  to dat_mem addr
- mem_wdata  out  DW  to dat_mem dat_in
- mem_rdata  in  DW  from dat_mem (combinational read)
- busy  out  1  high in PRIME or RUN
- done  out  1  high in DONE
- timeout  out  1  high in TMO (tied 0 without the macro)
- cycle_count  out  CW  RUN cycles of the last or current run

Behaviour:
- States: IDLE, PRIME, RUN, DONE, TMO.
- Reset (async): state=IDLE, core_reset=1, cycle_count=0, prime counter=0, busy=done=timeout=0.
- IDLE/DONE/TMO:
  - core_reset=1.
  - Host owns memory: host_gnt=host_req, mem_we=host_req&host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - host_rdata=mem_rdata same cycle (0-cycle latency); a write commits at the clock edge.
  - start -> PRIME at next edge; cycle_count cleared to 0 at that edge.
- PRIME:
  - core_reset=1, host_gnt=0, mem_we=0.
  - Stays exactly RST_CYC cycles, then -> RUN.
- RUN:
  - core_reset=0; the core owns memory: mem_* mirror core_*, and core_rdata=mem_rdata.
  - host_gnt=0; host requests stall and are not queued.
  - cycle_count increments every RUN cycle, including the cycle in which core_done is sampled high, and saturates at all-ones.
  - core_done=1 -> DONE at next edge.
- DONE: done=1; cycle_count frozen; the host may read results.
- Outside RUN, core_rdata=mem_rdata but is ignored by the core (held in reset). mem_* are driven by the host mux only.
- start is ignored in PRIME and RUN.
- start and host_req in the same IDLE cycle: the host access is granted that cycle and a write commits at the same edge the state moves to PRIME, so preload completes before the run.
- core_done is ignored outside RUN.
- reset asserted mid-RUN: immediately IDLE with core_reset=1. Memory contents are untouched.
- A new start from DONE or TMO reruns: cycle_count cleared, done/timeout drop at the PRIME entry edge.

Optional Feature:
- RUN_CTRL_WDOG_EN defined: in RUN, if cycle_count reaches MAX_CYCLES-1 while core_done=0 -> TMO at next edge.
  - TMO: timeout=1, core_reset=1, host owns memory, start is accepted as in DONE.
  - If core_done=1 on that same cycle, DONE takes priority.
- Undefined: no TMO state and timeout is tied 0; a run without core_done never ends except by reset.

Decomposition:
- Package run_ctrl_pkg: state enum (IDLE, PRIME, RUN, DONE, TMO), default AW/DW/CW constants, and an owner enum (OWN_HOST, OWN_CORE) used by the memory mux.
- Sub-module sat_counter (width parameter; clear, inc, saturate) for cycle_count. The PRIME counter stays inline.

Test Plan:
- Host writes 0x5A to addr 0x10 in IDLE, then reads addr 0x10 -> host_gnt=1 both cycles; host_rdata=0x5A on the read cycle.
- Pulse start, core_done raised on the 7th RUN cycle -> PRIME lasts exactly 2 cycles; done=1 next edge; cycle_count=7; core_reset=1 in DONE.
- host_req=1 (write 0xFF to addr 0x10) during RUN while core_we=1 to addr 0x20 with data 0x33 -> host_gnt=0, mem_addr=0x20, mem_wdata=0x33; addr 0x10 unchanged.
- start and host write (addr 0x00, data 0x03) in the same IDLE cycle -> addr 0x00 holds 0x03 when RUN begins.
- Assert reset 3 cycles into RUN -> state IDLE immediately, cycle_count=0, busy=0, core_reset=1.
- With RUN_CTRL_WDOG_EN, MAX_CYCLES=16, core_done held 0 -> timeout=1 after the 16th RUN cycle, cycle_count=16, done=0; a new start clears timeout.
